serial_subtractor: RTL and testbench

Parametrised multi-cycle subtractor that computes `a - b - bin` over `WIDTH` bits, processing `STEP` bits per clock LSB-first through a chained full-subtractor slice and a registered borrow. It succeeds the single-bit combinational full subtractor in the behavioural-model set. It adds operand latching, a start/busy/done handshake, borrow-out and signed-overflow flags, and a width/throughput trade-off set at elaboration.

---
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle LSB-first subtractor computing a - b - bin
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic [STEP-1:0]       slice_diff;
  logic                  borrow_next;
  logic                  borrow_msb;
  logic [WIDTH+STEP-1:0] res_cat;
  logic [WIDTH-1:0]      res_next;

  // Ripple the current STEP-bit slice through full-subtractor cells; keep the
  // borrow entering the top cell so the last slice can flag signed overflow.
  always_comb begin
    slice_diff  = '0;
    borrow_next = borrow;
    borrow_msb  = borrow;
    for (int i = 0; i < STEP; i++) begin
      borrow_msb    = borrow_next;
      slice_diff[i] = a_q[i] ^ b_q[i] ^ borrow_next;
      borrow_next   = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & borrow_next);
    end
  end

  // New slice enters at the top so the first slice ends up at bit 0 after N shifts.
  assign res_cat  = {slice_diff, res_q};
  assign res_next = res_cat[WIDTH+STEP-1:STEP];

  // Control FSM with registered outputs, operand shifters and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= BUSY;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        BUSY: begin
          a_q    <= a_q >> STEP;
          b_q    <= b_q >> STEP;
          res_q  <= res_next;
          borrow <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= res_next;
            bout  <= borrow_next;
            ovf   <= borrow_msb ^ borrow_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [3:0] busy_o;
  logic [3:0] done_o;
  logic [3:0] bout_o;
  logic [3:0] ovf_o;
  logic [7:0] d0;
  logic [2:0] d1;
  logic [2:0] d2;
  logic [7:0] d3;

  int nchecks = 0;
  int nerrs   = 0;

  // Instance 0: W8/S1, 1: W3/S1, 2: W3/S3, 3: W8/S4
  serial_subtractor #(.WIDTH(8), .STEP(1)) u_w8s1 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a), .b(b), .bin(bin),
    .busy(busy_o[0]), .done(done_o[0]), .diff(d0), .bout(bout_o[0]), .ovf(ovf_o[0]));
  serial_subtractor #(.WIDTH(3), .STEP(1)) u_w3s1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a[2:0]), .b(b[2:0]), .bin(bin),
    .busy(busy_o[1]), .done(done_o[1]), .diff(d1), .bout(bout_o[1]), .ovf(ovf_o[1]));
  serial_subtractor #(.WIDTH(3), .STEP(3)) u_w3s3 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a[2:0]), .b(b[2:0]), .bin(bin),
    .busy(busy_o[2]), .done(done_o[2]), .diff(d2), .bout(bout_o[2]), .ovf(ovf_o[2]));
  serial_subtractor #(.WIDTH(8), .STEP(4)) u_w8s4 (
    .clk(clk), .rst(rst), .start(start[3]), .a(a), .b(b), .bin(bin),
    .busy(busy_o[3]), .done(done_o[3]), .diff(d3), .bout(bout_o[3]), .ovf(ovf_o[3]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 1 || k == 2) ? 3 : 8;
  endfunction

  function automatic int cycles_of(input int k);
    case (k)
      0: return 8;
      1: return 3;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] diff_of(input int k);
    case (k)
      0: return {24'd0, d0};
      1: return {29'd0, d1};
      2: return {29'd0, d2};
      default: return {24'd0, d3};
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int w, input int av, input int bv, input int bi,
                                output int d, output int bo, output int ov);
    int m;
    int sa;
    int sb;
    int sr;
    m  = 1 << w;
    d  = (((av - bv - bi) % m) + m) % m;
    bo = (av < bv + bi) ? 1 : 0;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    sr = sa - sb - bi;
    ov = (sr < -(m / 2) || sr > m / 2 - 1) ? 1 : 0;
  endfunction

  task automatic run_op(input int k, input int av, input int bv, input int bi, input bit glitch);
    int w, n, ed, eb, eo, nb, t;
    w  = width_of(k);
    n  = cycles_of(k);
    av = av & ((1 << w) - 1);
    bv = bv & ((1 << w) - 1);
    bi = bi & 1;
    model(w, av, bv, bi, ed, eb, eo);
    @(negedge clk);
    a = 8'(av); b = 8'(bv); bin = bi[0]; start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    nb = 0;
    t  = 0;
    while (done_o[k] !== 1'b1 && t < 40) begin
      if (busy_o[k] === 1'b1) nb++;
      if (glitch && t == 2) begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); start[k] = 1'b1;
      end else if (glitch && t == 3) begin
        start[k] = 1'b0;
      end
      t++;
      @(negedge clk);
    end
    check("done_timeout", 32'(t < 40), 32'd1);
    check("busy_cycles", 32'(nb), 32'(n));
    check("busy_at_done", {31'd0, busy_o[k]}, 32'd0);
    check("diff", diff_of(k), 32'(ed));
    check("bout", {31'd0, bout_o[k]}, 32'(eb));
    check("ovf", {31'd0, ovf_o[k]}, 32'(eo));
    @(negedge clk);
    check("done_single", {31'd0, done_o[k]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int npulse;
    int ed, eb, eo;
    rst = 1'b1; start = '0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_busy", {31'd0, busy_o[k]}, 32'd0);
      check("rst_done", {31'd0, done_o[k]}, 32'd0);
      check("rst_diff", diff_of(k), 32'd0);
      check("rst_bout", {31'd0, bout_o[k]}, 32'd0);
      check("rst_ovf", {31'd0, ovf_o[k]}, 32'd0);
    end
    rst = 1'b0;

    run_op(0, 8'h05, 8'h03, 0, 1'b0);
    run_op(0, 8'h00, 8'h01, 0, 1'b0);
    run_op(0, 8'h10, 8'h0F, 1, 1'b0);
    run_op(0, 8'h80, 8'h01, 0, 1'b0);
    run_op(0, 8'h7F, 8'hFF, 0, 1'b0);
    run_op(0, 8'h80, 8'h7F, 1, 1'b0);
    run_op(0, 8'h3C, 8'h5A, 1, 1'b1);

    for (int i = 0; i < 30; i++) run_op(0, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), 1'(i % 3 == 0));
    for (int i = 0; i < 30; i++) run_op(3, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), 1'b0);

    for (int k = 1; k <= 2; k++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          for (int c = 0; c < 2; c++)
            run_op(k, x, y, c, 1'b0);

    // start held high: a done pulse every N+1 cycles
    @(negedge clk);
    a = 8'h9C; b = 8'h2D; bin = 1'b1; start[0] = 1'b1;
    model(8, 'h9C, 'h2D, 1, ed, eb, eo);
    last = -1;
    npulse = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("held_excl", {31'd0, busy_o[0] & done_o[0]}, 32'd0);
      if (done_o[0] === 1'b1) begin
        if (last >= 0) check("held_period", 32'(c - last), 32'd9);
        check("held_diff", diff_of(0), 32'(ed));
        last = c;
        npulse++;
      end
    end
    start[0] = 1'b0;
    check("held_pulses", 32'(npulse), 32'd4);
    repeat (12) @(negedge clk);

    // reset in the 4th busy cycle, together with start
    run_op(0, 8'h05, 8'h03, 0, 1'b0);
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_o[0]}, 32'd1);
    rst = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; start[0] = 1'b0;
    check("midrst_busy", {31'd0, busy_o[0]}, 32'd0);
    check("midrst_done", {31'd0, done_o[0]}, 32'd0);
    check("midrst_diff", diff_of(0), 32'd0);
    check("midrst_bout", {31'd0, bout_o[0]}, 32'd0);
    check("midrst_ovf", {31'd0, ovf_o[0]}, 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("midrst_no_done", {31'd0, done_o[0] | busy_o[0]}, 32'd0);
    end
    run_op(0, 8'hC8, 8'h37, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
